nmea_rmc_parser: RTL and testbench
==================================

# nmea_rmc_parser

Byte-stream parser for the GPS receiver's NMEA output. It sits between the UART receiver and the timestamp/PPS alignment logic. It consumes decoded 8-bit characters, recognises `$GPRMC`/`$GNRMC` sentences, extracts the UTC `hhmmss` field as binary hours/minutes/seconds, and verifies the sentence checksum. It publishes the time with a one-cycle valid strobe, which the PPS logic latches on the next second edge.

## Interface
- `CHECK_SUM`, default 1: 1 means time is published only if the `*hh` checksum matches; 0 means it is published when `*` is seen and the checksum bytes are ignored.
- `MAX_LEN`, default 82: maximum sentence length in characters, counted from `$` inclusive.
- `clk`  in  1  system clock (axi_clock domain, 125 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `i_byte`  in  8  received character.
- `i_byte_valid`  in  1  `i_byte` is valid this cycle. At most one byte per cycle; gaps are arbitrary.
- `o_pattern_found`  out  1  one-cycle pulse: RMC header accepted.
- `o_hr`  out  5  hours, 0–23.
- `o_min`  out  6  minutes, 0–59.
- `o_sec`  out  6  seconds, 0–60 (leap second allowed).
- `o_time_valid`  out  1  one-cycle pulse: `o_hr`/`o_min`/`o_sec` updated.
- `o_cksum_err`  out  1  one-cycle pulse: sentence completed with a checksum mismatch.

## Operation
- All state advances only on cycles with `i_byte_valid=1`. Nothing changes on idle cycles.
- States: IDLE, HDR, TIME, SKIP, CK_HI, CK_LO.
- IDLE:
  - `$` clears the checksum, sets the length counter to 1 and moves to HDR.
  - All other bytes are ignored.
- HDR:
  - Match `G`, then `P` or `N`, then `R`, `M`, `C`, `,` in order.
  - Every header byte is XORed into the checksum.
  - Any mismatch moves to IDLE.
  - On the final `,`, pulse `o_pattern_found` and move to TIME.
- TIME:
  - Accept exactly 6 ASCII digits `0`–`9` into shadow registers.
  - Tens digits are combined with units as tens*10+units, computed on the units byte.
  - Any non-digit moves to IDLE.
  - After the 6th digit, move to SKIP.
- SKIP:
  - Consume bytes, XORing each into the checksum, until `*`. The `*` itself is not XORed.
  - On `*`: if CHECK_SUM=0, publish and move to IDLE; otherwise move to CK_HI.
- CK_HI, CK_LO:
  - Each accepts one hex digit (`0-9`, `A-F`, `a-f`).
  - A non-hex byte moves to IDLE without publishing.
- After CK_LO, compare the received byte with the XOR accumulator.
  - Match: if shadow hr≤23, min≤59 and sec≤60, publish. Out of range: silent drop.
  - Mismatch: pulse `o_cksum_err`; outputs unchanged.
  - Either way, move to IDLE.
- Publishing copies shadow hr/min/sec to the outputs and pulses `o_time_valid`.
- Restart: `$` in any state other than IDLE restarts the sentence (checksum cleared, length=1, state HDR). No error pulse is generated.
- Abort: CR or LF in any non-IDLE state moves to IDLE with no pulses.
- Length limit: the counter increments per accepted byte and saturates. Reaching MAX_LEN+1 before the sentence completes moves to IDLE with no pulses.
- Outputs hold their last published value until the next publish.

## Timing
- Reset values: `o_hr=0`, `o_min=0`, `o_sec=0`, `o_pattern_found=0`, `o_time_valid=0`, `o_cksum_err=0`. State is IDLE, checksum 0, length 0.
- `o_pattern_found`: registered, asserted the cycle after the accepted header `,`.
- `o_time_valid`: asserted the cycle after the last checksum byte (CHECK_SUM=1) or after the `*` byte (CHECK_SUM=0). New hr/min/sec are visible in the same cycle as the pulse.
- `o_cksum_err`: same cycle position as `o_time_valid`. The two pulses are mutually exclusive.
- All pulses are exactly one cycle wide, regardless of when the next `i_byte_valid` arrives.
- Back-to-back sentences with no idle cycles are supported. A `$` arriving in the cycle right after a publish is parsed normally.
- `rst` asserted mid-sentence discards the shadow registers. Outputs return to reset values on the next edge.

## Structure
- Package `nmea_pkg`:
  - state enum;
  - ASCII constants (`$`, `*`, `,`, CR, LF, header characters);
  - function for ASCII hex to nibble, returning a valid flag;
  - function for ASCII digit check.
- Sub-module `nmea_checksum`: 8-bit XOR accumulator with `clr` and `en` inputs and registered output. It is instantiated once and reused by any future GGA/ZDA parser.
- Top: FSM, digit shadow registers, length counter, output registers.

## Test plan
- Feed `$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A` + CRLF, one byte every 10 cycles → one `o_pattern_found`, then `o_time_valid` with hr=12, min=35, sec=19, and no `o_cksum_err`.
- Same sentence with the checksum changed to `*6B` → `o_cksum_err` pulse; outputs hold their previous values.
- `$GPGGA,...` sentence followed immediately by a valid `$GNRMC,235960,...` sentence with correct checksum → no pulses for GGA; second sentence publishes hr=23, min=59, sec=60.
- Time field `250000` with correct checksum → no `o_time_valid` and no `o_cksum_err`. Time field `12a519` → FSM returns to IDLE with no pulses.
- Sentence truncated by `$` mid-body, then a full valid sentence → only the second sentence publishes. A 90-character sentence with no `*` → no pulses.
- `rst` pulsed during SKIP, then a valid sentence → outputs read 0 after reset, then the correct published time. CHECK_SUM=0 build → `o_time_valid` the cycle after `*`.

Source files
------------

// File: rtl/nmea_pkg.sv
// Shared types, ASCII constants and character helpers for the NMEA sentence parsers.
package nmea_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_TIME,
    S_SKIP,
    S_CK_HI,
    S_CK_LO
  } state_t;

  localparam logic [7:0] ASC_DOLLAR = 8'h24;
  localparam logic [7:0] ASC_STAR   = 8'h2A;
  localparam logic [7:0] ASC_COMMA  = 8'h2C;
  localparam logic [7:0] ASC_CR     = 8'h0D;
  localparam logic [7:0] ASC_LF     = 8'h0A;
  localparam logic [7:0] ASC_G      = 8'h47;
  localparam logic [7:0] ASC_P      = 8'h50;
  localparam logic [7:0] ASC_N      = 8'h4E;
  localparam logic [7:0] ASC_R      = 8'h52;
  localparam logic [7:0] ASC_M      = 8'h4D;
  localparam logic [7:0] ASC_C      = 8'h43;

  // Returns {valid, nibble}; letters map via low nibble + 9 ('A'/'a' -> 10).
  function automatic logic [4:0] hex_nibble(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return {1'b1, c[3:0] + 4'd9};
    else
      return 5'd0;
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Header after '$': G, P|N, R, M, C, ','
  function automatic logic hdr_match(input logic [2:0] pos, input logic [7:0] c);
    case (pos)
      3'd0:    return c == ASC_G;
      3'd1:    return (c == ASC_P) || (c == ASC_N);
      3'd2:    return c == ASC_R;
      3'd3:    return c == ASC_M;
      3'd4:    return c == ASC_C;
      3'd5:    return c == ASC_COMMA;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nmea_checksum.sv
// 8-bit XOR accumulator for NMEA sentence checksums; clr has priority over en.
module nmea_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clr) sum <= 8'h00;
    else if (en)    sum <= sum ^ data;
  end

endmodule

// File: rtl/nmea_rmc_parser.sv
// $GPRMC/$GNRMC parser: extracts UTC hh/mm/ss, verifies the *hh checksum and
// publishes the time with a one-cycle strobe.
module nmea_rmc_parser
  import nmea_pkg::*;
#(
  parameter bit CHECK_SUM = 1'b1,
  parameter int MAX_LEN   = 82
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output logic       o_pattern_found,
  output logic [4:0] o_hr,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic       o_time_valid,
  output logic       o_cksum_err
);

  localparam int LW = $clog2(MAX_LEN + 2);

  state_t        state, state_n;
  logic [LW-1:0] len, len_n;
  logic [2:0]    idx, idx_n;
  logic [3:0]    tens, ck_hi;
  logic [6:0]    sh_hr, sh_min, sh_sec, pair_val;
  logic [7:0]    sum;
  logic [4:0]    hx;
  logic          cs_clr, cs_en, pf_set, pub, err, dig_we, ck_we, in_range;

  nmea_checksum u_cksum (
    .clk  (clk),
    .rst  (rst),
    .clr  (cs_clr),
    .en   (cs_en),
    .data (i_byte),
    .sum  (sum)
  );

  assign hx       = hex_nibble(i_byte);
  assign pair_val = 7'(tens) * 7'd10 + {3'b000, i_byte[3:0]};
  assign in_range = (sh_hr <= 7'd23) && (sh_min <= 7'd59) && (sh_sec <= 7'd60);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      len   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      len   <= len_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    len_n   = len;
    idx_n   = idx;
    cs_clr  = 1'b0;
    cs_en   = 1'b0;
    pf_set  = 1'b0;
    pub     = 1'b0;
    err     = 1'b0;
    dig_we  = 1'b0;
    ck_we   = 1'b0;
    if (i_byte_valid) begin
      if (i_byte == ASC_DOLLAR) begin
        state_n = S_HDR;
        cs_clr  = 1'b1;
        len_n   = LW'(1);
        idx_n   = '0;
      end else if (state != S_IDLE) begin
        if (i_byte == ASC_CR || i_byte == ASC_LF) begin
          state_n = S_IDLE;
        end else if (int'(len) >= MAX_LEN) begin
          // this byte would be character MAX_LEN+1
          state_n = S_IDLE;
        end else begin
          len_n = len + LW'(1);
          case (state)
            S_HDR: begin
              cs_en = 1'b1;
              if (!hdr_match(idx, i_byte)) state_n = S_IDLE;
              else if (idx == 3'd5) begin
                state_n = S_TIME;
                pf_set  = 1'b1;
                idx_n   = '0;
              end else idx_n = idx + 3'd1;
            end
            S_TIME: begin
              cs_en = 1'b1;
              if (!is_digit(i_byte)) state_n = S_IDLE;
              else begin
                dig_we = 1'b1;
                idx_n  = idx + 3'd1;
                if (idx == 3'd5) state_n = S_SKIP;
              end
            end
            S_SKIP: begin
              if (i_byte == ASC_STAR) begin
                if (CHECK_SUM) state_n = S_CK_HI;
                else begin
                  pub     = in_range;
                  state_n = S_IDLE;
                end
              end else cs_en = 1'b1;
            end
            S_CK_HI: begin
              if (hx[4]) begin
                ck_we   = 1'b1;
                state_n = S_CK_LO;
              end else state_n = S_IDLE;
            end
            S_CK_LO: begin
              state_n = S_IDLE;
              if (hx[4]) begin
                if ({ck_hi, hx[3:0]} == sum) pub = in_range;
                else                         err = 1'b1;
              end
            end
            default: state_n = S_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tens            <= '0;
      ck_hi           <= '0;
      sh_hr           <= '0;
      sh_min          <= '0;
      sh_sec          <= '0;
      o_hr            <= '0;
      o_min           <= '0;
      o_sec           <= '0;
      o_pattern_found <= 1'b0;
      o_time_valid    <= 1'b0;
      o_cksum_err     <= 1'b0;
    end else begin
      o_pattern_found <= pf_set;
      o_time_valid    <= pub;
      o_cksum_err     <= err;
      if (ck_we) ck_hi <= hx[3:0];
      // even index = tens digit, odd index completes the pair
      if (dig_we) begin
        if (!idx[0]) tens <= i_byte[3:0];
        else begin
          case (idx)
            3'd1:    sh_hr  <= pair_val;
            3'd3:    sh_min <= pair_val;
            default: sh_sec <= pair_val;
          endcase
        end
      end
      if (pub) begin
        o_hr  <= sh_hr[4:0];
        o_min <= sh_min[5:0];
        o_sec <= sh_sec[5:0];
      end
    end
  end

endmodule

// File: tb/tb_nmea_rmc_parser.sv
// Directed bench for nmea_rmc_parser: sentence table plus reset, latency and CHECK_SUM=0 sequences.
module tb_nmea_rmc_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_byte;
  logic       i_byte_valid;
  logic       pf, tv, ce, pf0, tv0, ce0;
  logic [4:0] hr, hr0;
  logic [5:0] mn, sc, mn0, sc0;

  always #5 clk = ~clk;

  nmea_rmc_parser #(.CHECK_SUM(1'b1), .MAX_LEN(82)) dut (
    .clk(clk), .rst(rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_pattern_found(pf), .o_hr(hr), .o_min(mn), .o_sec(sc),
    .o_time_valid(tv), .o_cksum_err(ce)
  );

  nmea_rmc_parser #(.CHECK_SUM(1'b0), .MAX_LEN(82)) dut0 (
    .clk(clk), .rst(rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_pattern_found(pf0), .o_hr(hr0), .o_min(mn0), .o_sec(sc0),
    .o_time_valid(tv0), .o_cksum_err(ce0)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse counters; a stretched pulse shows up as an extra count
  int pf_n = 0, tv_n = 0, ce_n = 0, both_n = 0, tv_cyc = -1;
  int tv0_n = 0, tv0_cyc = -1, ce0_n = 0;
  always @(negedge clk) begin
    if (pf) pf_n++;
    if (tv) begin tv_n++; tv_cyc = cyc; end
    if (ce) ce_n++;
    if (tv && ce) both_n++;
    if (tv0) begin tv0_n++; tv0_cyc = cyc; end
    if (ce0) ce0_n++;
  end

  int tests = 0, failed = 0;
  int bcyc, star_cyc, last_cyc;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    i_byte       = b;
    i_byte_valid = 1'b1;
    bcyc         = cyc + 1;
    if (gap > 0) begin
      @(negedge clk);
      i_byte_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic send_str(input string s, input int gap, input bit crlf);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], gap);
      if (s[i] == 8'h2A) star_cyc = bcyc;
      last_cyc = bcyc;
    end
    if (crlf) begin
      send_byte(8'h0D, gap);
      send_byte(8'h0A, gap);
    end
    @(negedge clk);
    i_byte_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  function automatic string mk(input string body, input bit bad, input bit lower);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < body.len(); i++) x ^= body[i];
    if (bad) x ^= 8'h01;
    if (lower) return {body, "*", $sformatf("%02x", x)};
    return {body, "*", $sformatf("%02X", x)};
  endfunction

  function automatic string pad(input string head, input int n);
    string s;
    s = head;
    while (s.len() < n) s = {s, "A"};
    return s;
  endfunction

  typedef struct {
    string s;
    int    pf, tv, err, hr, mn, sc;
  } vec_t;
  vec_t vt[$];

  task automatic add(input string s, input int epf, input int etv, input int eerr,
                     input int ehr, input int emn, input int esc);
    vec_t v;
    v.s = s; v.pf = epf; v.tv = etv; v.err = eerr; v.hr = ehr; v.mn = emn; v.sc = esc;
    vt.push_back(v);
  endtask

  string rmc1 = "$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W";
  int p0, t0, e0, t00;

  initial begin
    add(mk(rmc1, 1'b1, 1'b0),                                          1, 0, 1, 12, 35, 19);
    add({mk("$GPGGA,092750,4717.1,N", 1'b0, 1'b0),
         mk("$GNRMC,235960,A,1,N", 1'b0, 1'b0)},                       1, 1, 0, 23, 59, 60);
    add(mk("$GPRMC,250000,A", 1'b0, 1'b0),                             1, 0, 0, 23, 59, 60);
    add(mk("$GPRMC,12a519,A", 1'b0, 1'b0),                             1, 0, 0, 23, 59, 60);
    add({"$GPRMC,0102", mk("$GPRMC,010203,V", 1'b0, 1'b0)},            2, 1, 0,  1,  2,  3);
    add({mk("$GNRMC,045907,A", 1'b0, 1'b1),
         mk("$GPRMC,060708,A", 1'b0, 1'b0)},                           2, 2, 0,  6,  7,  8);
    add(mk(pad("$GPRMC,101010,", 79), 1'b0, 1'b0),                     1, 1, 0, 10, 10, 10);
    add(mk(pad("$GPRMC,202020,", 80), 1'b0, 1'b0),                     1, 0, 0, 10, 10, 10);
    add(pad("$GPRMC,111111,", 90),                                     1, 0, 0, 10, 10, 10);
    add("$GPRMC,123456,A*G1",                                          1, 0, 0, 10, 10, 10);
    add("$GPRMC,131313,A\r*00",                                        1, 0, 0, 10, 10, 10);

    rst = 1'b1; i_byte = 8'h00; i_byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_hr", hr, 0);
    chk("reset_min", mn, 0);
    chk("reset_sec", sc, 0);
    chk("reset_pf", pf, 0);
    chk("reset_tv", tv, 0);
    chk("reset_err", ce, 0);

    // reference sentence, one byte every 10 cycles
    p0 = pf_n; t0 = tv_n; e0 = ce_n;
    send_str({rmc1, "*6A"}, 9, 1'b1);
    chk("ref_pf", pf_n - p0, 1);
    chk("ref_tv", tv_n - t0, 1);
    chk("ref_err", ce_n - e0, 0);
    chk("ref_hr", hr, 12);
    chk("ref_min", mn, 35);
    chk("ref_sec", sc, 19);
    chk("ref_tv_latency", tv_cyc, last_cyc);

    foreach (vt[k]) begin
      p0 = pf_n; t0 = tv_n; e0 = ce_n;
      send_str(vt[k].s, 0, 1'b1);
      chk($sformatf("vec%0d_pf", k), pf_n - p0, vt[k].pf);
      chk($sformatf("vec%0d_tv", k), tv_n - t0, vt[k].tv);
      chk($sformatf("vec%0d_err", k), ce_n - e0, vt[k].err);
      chk($sformatf("vec%0d_hr", k), hr, vt[k].hr);
      chk($sformatf("vec%0d_min", k), mn, vt[k].mn);
      chk($sformatf("vec%0d_sec", k), sc, vt[k].sc);
    end

    // reset while in SKIP
    send_str("$GPRMC,213141,A,1", 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_hr", hr, 0);
    chk("midrst_min", mn, 0);
    chk("midrst_sec", sc, 0);
    t0 = tv_n;
    send_str(mk("$GPRMC,213141,A", 1'b0, 1'b0), 1, 1'b1);
    chk("postrst_tv", tv_n - t0, 1);
    chk("postrst_hr", hr, 21);
    chk("postrst_min", mn, 31);
    chk("postrst_sec", sc, 41);

    // CHECK_SUM=0 publishes on '*' and ignores a wrong checksum
    t00 = tv0_n; e0 = ce_n;
    send_str(mk("$GPRMC,030405,A", 1'b1, 1'b0), 2, 1'b1);
    chk("ck0_tv", tv0_n - t00, 1);
    chk("ck0_tv_latency", tv0_cyc, star_cyc);
    chk("ck0_hr", hr0, 3);
    chk("ck0_min", mn0, 4);
    chk("ck0_sec", sc0, 5);
    chk("ck0_err_count", ce0_n, 0);
    chk("ck1_err_same_stream", ce_n - e0, 1);

    chk("tv_err_exclusive", both_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
